// File: rtl/pac_rr_requester.sv
// pac_rr_requester: requester endpoint for a weighted round-robin arbiter.
// Buffers burst commands, requests with an (optionally aged) weight, then
// owns the bus for the burst length and re-requests while work remains.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   base_weight [W]     configured weight, sampled every cycle
//   in_valid/in_ready   command handshake (in_ready = !full)
//   in_data [DATA_W]    payload word
//   in_len [2]          burst beats minus one
//   req, weight [W]     registered request and effective weight
//   gnt                 single-cycle grant
//   bus_valid, bus_data, bus_beat, bus_last   owned-bus beat signals
//   pending             FIFO occupancy
//
// Optional feature macro: PAC_RR_AGING_EN (wait-time aging of weight).
module pac_rr_requester #(
    parameter int unsigned W         = 3,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned AGE_SHIFT = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [W-1:0]               base_weight,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [1:0]                 in_len,
    output logic                       req,
    output logic [W-1:0]               weight,
    input  logic                       gnt,
    output logic                       bus_valid,
    output logic [DATA_W-1:0]          bus_data,
    output logic [1:0]                 bus_beat,
    output logic                       bus_last,
    output logic [$clog2(DEPTH):0]     pending
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        OWN  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [1:0]        mem_len_q  [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [1:0]        beat_q, beat_d;
    logic [W-1:0]      weight_q, weight_d;
    logic              full, push, pop, last;

    // Full blocks pushes even when a pop happens in the same cycle.
    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign last     = (state_q == OWN) && (beat_q == mem_len_q[rd_ptr_q]);
    assign pop      = last;
    assign count_d  = count_q + CW'(push) - CW'(pop);

    assign req       = (state_q == REQ);
    assign weight    = weight_q;
    assign bus_valid = (state_q == OWN);
    assign bus_data  = bus_valid ? mem_data_q[rd_ptr_q] : '0;
    assign bus_beat  = beat_q;
    assign bus_last  = last;
    assign pending   = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_data_q[i] <= '0;
                mem_len_q[i]  <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_data_q[wr_ptr_q] <= in_data;
                mem_len_q[wr_ptr_q]  <= in_len;
                wr_ptr_q             <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = '0;
        case (state_q)
            IDLE: begin
                if (count_q != '0 || push) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (gnt) begin
                    state_d = OWN;
                end
            end
            OWN: begin
                // A push landing on the last beat keeps us requesting.
                if (last) begin
                    state_d = (count_d != '0) ? REQ : IDLE;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PAC_RR_AGING_EN
    logic [AGE_SHIFT-1:0] wait_cnt_q, wait_cnt_d;
    logic [W-1:0]         age_q, age_d;
    logic [W:0]           wsum;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        age_d      = age_q;
        if (state_q == IDLE || (state_q == REQ && gnt)) begin
            wait_cnt_d = '0;
            age_d      = '0;
        end else if (state_q == REQ) begin
            wait_cnt_d = wait_cnt_q + AGE_SHIFT'(1);
            if ((&wait_cnt_q) && !(&age_q)) begin
                age_d = age_q + W'(1);
            end
        end
        wsum     = {1'b0, base_weight} + {1'b0, age_q};
        weight_d = wsum[W] ? '1 : wsum[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            age_q      <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            age_q      <= age_d;
        end
    end
`else
    always_comb begin
        weight_d = base_weight;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            weight_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            weight_q <= weight_d;
        end
    end

endmodule

// File: tb/tb_pac_rr_requester.sv
// tb_pac_rr_requester: directed self-checking bench for pac_rr_requester.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_pac_rr_requester;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] base_weight = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [1:0] in_len = '0;
    logic       req;
    logic [2:0] weight;
    logic       gnt = 1'b0;
    logic       bus_valid;
    logic [7:0] bus_data;
    logic [1:0] bus_beat;
    logic       bus_last;
    logic [1:0] pending;

    int checks = 0;
    int errors = 0;

`ifdef PAC_RR_AGING_EN
    localparam logic [2:0] EXP_AGE1 = 3'd6;
    localparam logic [2:0] EXP_AGE2 = 3'd7;
`else
    localparam logic [2:0] EXP_AGE1 = 3'd5;
    localparam logic [2:0] EXP_AGE2 = 3'd5;
`endif

    pac_rr_requester #(
        .W(3), .DATA_W(8), .DEPTH(2), .AGE_SHIFT(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .base_weight(base_weight),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_len(in_len), .req(req), .weight(weight), .gnt(gnt),
        .bus_valid(bus_valid), .bus_data(bus_data), .bus_beat(bus_beat),
        .bus_last(bus_last), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", req); end
        checks++; if (weight !== 3'd0) begin errors++; $display("FAIL rst_weight: got %0d want 0", weight); end
        checks++; if (bus_valid !== 1'b0 || bus_last !== 1'b0) begin errors++; $display("FAIL rst_bus: valid %b last %b want 0 0", bus_valid, bus_last); end
        checks++; if (bus_data !== 8'h00 || bus_beat !== 2'd0) begin errors++; $display("FAIL rst_bus_data: data %h beat %0d want 00 0", bus_data, bus_beat); end
        checks++; if (pending !== 2'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_fifo: pending %0d ready %b want 0 1", pending, in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        base_weight = 3'd2;
        in_valid = 1'b1; in_data = 8'hA5; in_len = 2'd0;
        step();
        in_valid = 1'b0;
        checks++; if (req !== 1'b1 || weight !== 3'd2) begin errors++; $display("FAIL single_req: req %b weight %0d want 1 2", req, weight); end
        checks++; if (pending !== 2'd1) begin errors++; $display("FAIL single_pending: got %0d want 1", pending); end
        step(); step();
        checks++; if (req !== 1'b1 || weight !== 3'd2) begin errors++; $display("FAIL single_hold: req %b weight %0d want 1 2", req, weight); end
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        checks++; if (req !== 1'b0 || bus_valid !== 1'b1) begin errors++; $display("FAIL single_own: req %b valid %b want 0 1", req, bus_valid); end
        checks++; if (bus_data !== 8'hA5 || bus_beat !== 2'd0 || bus_last !== 1'b1) begin errors++; $display("FAIL single_beat: data %h beat %0d last %b want a5 0 1", bus_data, bus_beat, bus_last); end
        step();
        checks++; if (req !== 1'b0 || bus_valid !== 1'b0 || pending !== 2'd0) begin errors++; $display("FAIL single_idle: req %b valid %b pending %0d want 0 0 0", req, bus_valid, pending); end
        step();
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL single_stay_idle: req %b want 0", req); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_data = 8'h11; in_len = 2'd3;
        step();
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL b2b_req1: got %b want 1", req); end
        in_data = 8'h22; in_len = 2'd1;
        gnt = 1'b1;
        step();
        in_valid = 1'b0; gnt = 1'b0;
        checks++; if (pending !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: pending %0d ready %b want 2 0", pending, in_ready); end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (bus_valid !== 1'b1 || bus_data !== 8'h11 || bus_beat !== 2'(b) || bus_last !== (b == 3)) begin
                errors++;
                $display("FAIL b2b_beat_a%0d: valid %b data %h beat %0d last %b", b, bus_valid, bus_data, bus_beat, bus_last);
            end
            step();
        end
        checks++; if (req !== 1'b1 || bus_valid !== 1'b0 || pending !== 2'd1) begin errors++; $display("FAIL b2b_rereq: req %b valid %b pending %0d want 1 0 1", req, bus_valid, pending); end
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (bus_valid !== 1'b1 || bus_data !== 8'h22 || bus_beat !== 2'(b) || bus_last !== (b == 1)) begin
                errors++;
                $display("FAIL b2b_beat_b%0d: valid %b data %h beat %0d last %b", b, bus_valid, bus_data, bus_beat, bus_last);
            end
            step();
        end
        checks++; if (req !== 1'b0 || bus_valid !== 1'b0 || pending !== 2'd0) begin errors++; $display("FAIL b2b_idle: req %b valid %b pending %0d want 0 0 0", req, bus_valid, pending); end
    endtask

    task automatic test_aging();
        base_weight = 3'd5;
        in_valid = 1'b1; in_data = 8'h55; in_len = 2'd0;
        step();
        checks++; if (req !== 1'b1 || weight !== 3'd5) begin errors++; $display("FAIL age_start: req %b weight %0d want 1 5", req, weight); end
        in_data = 8'h66;
        step();
        in_valid = 1'b0;
        repeat (7) step();
        checks++; if (weight !== 3'd5) begin errors++; $display("FAIL age_r8: got %0d want 5", weight); end
        step();
        checks++; if (weight !== EXP_AGE1) begin errors++; $display("FAIL age_r9: got %0d want %0d", weight, EXP_AGE1); end
        repeat (7) step();
        checks++; if (weight !== EXP_AGE1) begin errors++; $display("FAIL age_r16: got %0d want %0d", weight, EXP_AGE1); end
        step();
        checks++; if (weight !== EXP_AGE2) begin errors++; $display("FAIL age_r17: got %0d want %0d", weight, EXP_AGE2); end
        repeat (13) step();
        checks++; if (weight !== EXP_AGE2 || req !== 1'b1) begin errors++; $display("FAIL age_sat: weight %0d req %b want %0d 1", weight, req, EXP_AGE2); end
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        checks++; if (bus_data !== 8'h55 || bus_last !== 1'b1) begin errors++; $display("FAIL age_beat: data %h last %b want 55 1", bus_data, bus_last); end
        step();
        checks++; if (req !== 1'b1 || weight !== 3'd5) begin errors++; $display("FAIL age_cleared: req %b weight %0d want 1 5", req, weight); end
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        checks++; if (bus_data !== 8'h66 || bus_valid !== 1'b1) begin errors++; $display("FAIL age_beat2: data %h valid %b want 66 1", bus_data, bus_valid); end
        step();
        checks++; if (req !== 1'b0 || pending !== 2'd0) begin errors++; $display("FAIL age_idle: req %b pending %0d want 0 0", req, pending); end
    endtask

    task automatic test_fill_during_own();
        in_valid = 1'b1; in_data = 8'hC1; in_len = 2'd3;
        step();
        in_valid = 1'b0;
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        checks++; if (in_ready !== 1'b1 || pending !== 2'd1) begin errors++; $display("FAIL fill_beat0: ready %b pending %0d want 1 1", in_ready, pending); end
        in_valid = 1'b1; in_data = 8'hB2; in_len = 2'd0;
        step();
        in_data = 8'hCC; in_len = 2'd2;
        for (int b = 1; b < 4; b++) begin
            checks++;
            if (in_ready !== 1'b0 || pending !== 2'd2 || bus_beat !== 2'(b)) begin
                errors++;
                $display("FAIL fill_full%0d: ready %b pending %0d beat %0d", b, in_ready, pending, bus_beat);
            end
            if (b < 3) step();
        end
        checks++; if (bus_last !== 1'b1) begin errors++; $display("FAIL fill_pop: last %b want 1", bus_last); end
        step();
        checks++; if (in_ready !== 1'b1 || pending !== 2'd1 || req !== 1'b1) begin errors++; $display("FAIL fill_after_pop: ready %b pending %0d req %b want 1 1 1", in_ready, pending, req); end
        in_valid = 1'b0;
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        checks++; if (bus_data !== 8'hB2 || bus_last !== 1'b1) begin errors++; $display("FAIL fill_second: data %h last %b want b2 1", bus_data, bus_last); end
        step();
        checks++; if (pending !== 2'd0 || req !== 1'b0) begin errors++; $display("FAIL fill_dropped: pending %0d req %b want 0 0", pending, req); end
    endtask

    task automatic test_stray_gnt();
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        checks++; if (req !== 1'b0 || bus_valid !== 1'b0) begin errors++; $display("FAIL stray_idle: req %b valid %b want 0 0", req, bus_valid); end
        in_valid = 1'b1; in_data = 8'h3C; in_len = 2'd2;
        step();
        in_valid = 1'b0;
        gnt = 1'b1;
        step();
        checks++; if (bus_beat !== 2'd0 || bus_data !== 8'h3C) begin errors++; $display("FAIL stray_b0: beat %0d data %h want 0 3c", bus_beat, bus_data); end
        step();
        gnt = 1'b0;
        checks++; if (bus_beat !== 2'd1 || bus_last !== 1'b0) begin errors++; $display("FAIL stray_b1: beat %0d last %b want 1 0", bus_beat, bus_last); end
        step();
        checks++; if (bus_beat !== 2'd2 || bus_last !== 1'b1) begin errors++; $display("FAIL stray_b2: beat %0d last %b want 2 1", bus_beat, bus_last); end
        step();
        checks++; if (bus_valid !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL stray_end: valid %b req %b want 0 0", bus_valid, req); end
    endtask

    task automatic test_reset_mid_burst();
        base_weight = 3'd3;
        in_valid = 1'b1; in_data = 8'h77; in_len = 2'd3;
        step();
        in_data = 8'h88; in_len = 2'd0;
        gnt = 1'b1;
        step();
        in_valid = 1'b0; gnt = 1'b0;
        step();
        checks++; if (bus_beat !== 2'd1 || bus_valid !== 1'b1) begin errors++; $display("FAIL mid_beat1: beat %0d valid %b want 1 1", bus_beat, bus_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus_valid !== 1'b0 || bus_data !== 8'h00 || bus_beat !== 2'd0 || bus_last !== 1'b0) begin errors++; $display("FAIL mid_bus: valid %b data %h beat %0d last %b", bus_valid, bus_data, bus_beat, bus_last); end
        checks++; if (req !== 1'b0 || weight !== 3'd0 || pending !== 2'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_ctrl: req %b weight %0d pending %0d ready %b", req, weight, pending, in_ready); end
        #2;
        rst_n = 1'b1;
        step();
        checks++; if (req !== 1'b0 || pending !== 2'd0) begin errors++; $display("FAIL mid_after: req %b pending %0d want 0 0", req, pending); end
        in_valid = 1'b1; in_data = 8'h5A; in_len = 2'd0;
        step();
        in_valid = 1'b0;
        checks++; if (req !== 1'b1 || weight !== 3'd3) begin errors++; $display("FAIL mid_req: req %b weight %0d want 1 3", req, weight); end
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        checks++; if (bus_data !== 8'h5A || bus_last !== 1'b1 || bus_valid !== 1'b1) begin errors++; $display("FAIL mid_serve: data %h last %b valid %b", bus_data, bus_last, bus_valid); end
        step();
        checks++; if (req !== 1'b0 || pending !== 2'd0) begin errors++; $display("FAIL mid_idle: req %b pending %0d want 0 0", req, pending); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_aging();
        test_fill_during_own();
        test_stray_gnt();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
